// File: rtl/prg_loader_pkg.sv
// Shared encoding for the brainhack program loader and core decode.
// Command codes, the HALT terminator and the FSM state type live here so that
// the loader's encoder and the core's decoder cannot disagree.
package prg_loader_pkg;

    localparam int INSTR_W = 4;

    localparam logic [INSTR_W-1:0] OP_INC   = 4'h0;  // '+'
    localparam logic [INSTR_W-1:0] OP_DEC   = 4'h1;  // '-'
    localparam logic [INSTR_W-1:0] OP_RIGHT = 4'h2;  // '>'
    localparam logic [INSTR_W-1:0] OP_LEFT  = 4'h3;  // '<'
    localparam logic [INSTR_W-1:0] OP_OPEN  = 4'h4;  // '['
    localparam logic [INSTR_W-1:0] OP_CLOSE = 4'h5;  // ']'
    localparam logic [INSTR_W-1:0] OP_OUT   = 4'h6;  // '.'
    localparam logic [INSTR_W-1:0] OP_IN    = 4'h7;  // ','
    localparam logic [INSTR_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_TERM = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/bf_char_encoder.sv
// Combinational classifier: maps an ASCII source byte to its command code and
// flags whether it is a command at all and whether it opens or closes a loop.
module bf_char_encoder (
    input  logic       [7:0] ch,
    output logic             is_cmd,
    output logic             is_open,
    output logic             is_close,
    output logic       [3:0] code
);
    import prg_loader_pkg::*;

    // Decode the eight command characters; anything else is a comment.
    always_comb begin
        is_cmd   = 1'b1;
        is_open  = 1'b0;
        is_close = 1'b0;
        code     = OP_INC;
        case (ch)
            8'h2B: code = OP_INC;                           // '+'
            8'h2D: code = OP_DEC;                           // '-'
            8'h3E: code = OP_RIGHT;                         // '>'
            8'h3C: code = OP_LEFT;                          // '<'
            8'h5B: begin code = OP_OPEN;  is_open  = 1'b1; end
            8'h5D: begin code = OP_CLOSE; is_close = 1'b1; end
            8'h2E: code = OP_OUT;                           // '.'
            8'h2C: code = OP_IN;                            // ','
            default: is_cmd = 1'b0;
        endcase
    end

endmodule

// File: rtl/prg_loader.sv
// Program loader: filters and encodes a source byte stream into program RAM,
// terminates the image with HALT, checks bracket balance and capacity, and
// keeps the core held until a complete, valid image has been written.
module prg_loader #(
    parameter int PRGMEM_ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH       = 4,
    parameter int DEPTH_WIDTH       = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         prg_we,
    output logic [PRGMEM_ADDR_WIDTH-1:0] prg_addr,
    output logic [INSTR_WIDTH-1:0]       prg_data,
    output logic [PRGMEM_ADDR_WIDTH-1:0] prg_len,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         error
);
    import prg_loader_pkg::*;

    // Last address is reserved for HALT, so commands may only use 0..ADDR_LAST-1.
    localparam logic [PRGMEM_ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [DEPTH_WIDTH-1:0]       DEPTH_MAX = '1;

    state_t                         state, state_n;
    logic [PRGMEM_ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_n;
    logic [DEPTH_WIDTH-1:0]         depth, depth_n;
    logic                           we_n;
    logic [PRGMEM_ADDR_WIDTH-1:0]   addr_n;
    logic [INSTR_WIDTH-1:0]         data_n;
    logic [PRGMEM_ADDR_WIDTH-1:0]   len_n;

    logic       is_cmd, is_open, is_close;
    logic [3:0] code;
    logic       fail;

    bf_char_encoder u_enc (
        .ch       (in_data),
        .is_cmd   (is_cmd),
        .is_open  (is_open),
        .is_close (is_close),
        .code     (code)
    );

    // Any one of these makes the current byte fatal; it is then never written.
    assign fail = (is_cmd   && (wr_ptr == ADDR_LAST)) ||
                  (is_close && (depth == '0))        ||
                  (is_open  && (depth == DEPTH_MAX));

    // Status outputs decode directly from the registered state.
    always_comb begin
        in_ready = (state == ST_LOAD);
        done     = (state == ST_DONE);
        error    = (state == ST_ERR);
        cpu_hold = (state != ST_DONE);
    end

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        depth_n  = depth;
        we_n     = 1'b0;
        addr_n   = prg_addr;
        data_n   = prg_data;
        len_n    = prg_len;
        case (state)
            ST_LOAD: begin
                if (in_valid) begin
                    if (fail) begin
                        state_n = ST_ERR;
                    end else begin
                        if (is_cmd) begin
                            we_n     = 1'b1;
                            addr_n   = wr_ptr;
                            data_n   = INSTR_WIDTH'(code);
                            wr_ptr_n = wr_ptr + 1'b1;
                        end
                        if (is_open)  depth_n = depth + 1'b1;
                        if (is_close) depth_n = depth - 1'b1;
                        if (in_last)  state_n = ST_TERM;
                    end
                end
            end
            ST_TERM: begin
                // HALT is written even for an unbalanced image; the error flag
                // tells the core not to trust it.
                we_n   = 1'b1;
                addr_n = wr_ptr;
                data_n = INSTR_WIDTH'(OP_HALT);
                if (depth != '0) begin
                    state_n = ST_ERR;
                end else begin
                    state_n = ST_DONE;
                    len_n   = wr_ptr;
                end
            end
            default: ;
        endcase
    end

    // State, counters and registered RAM-write outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_LOAD;
            wr_ptr   <= '0;
            depth    <= '0;
            prg_we   <= 1'b0;
            prg_addr <= '0;
            prg_data <= '0;
            prg_len  <= '0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            depth    <= depth_n;
            prg_we   <= we_n;
            prg_addr <= addr_n;
            prg_data <= data_n;
            prg_len  <= len_n;
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: a default-size instance (a_*) and a tiny one
// (b_*, 4-word RAM, nesting depth 1) for capacity and depth limits.
module tb_prg_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_valid = 1'b0, a_last = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready, a_we, a_hold, a_done, a_err;
    logic [7:0] a_addr, a_len;
    logic [3:0] a_pdata;

    logic       b_valid = 1'b0, b_last = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready, b_we, b_hold, b_done, b_err;
    logic [1:0] b_addr, b_len;
    logic [3:0] b_pdata;

    int checks = 0;
    int errors = 0;
    int log_a[$];
    int log_b[$];

    always #5 clk = ~clk;

    prg_loader #(.PRGMEM_ADDR_WIDTH(8), .INSTR_WIDTH(4), .DEPTH_WIDTH(4)) dut_a (
        .clock(clk), .reset(rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .in_last(a_last), .prg_we(a_we), .prg_addr(a_addr),
        .prg_data(a_pdata), .prg_len(a_len), .cpu_hold(a_hold), .done(a_done),
        .error(a_err)
    );

    prg_loader #(.PRGMEM_ADDR_WIDTH(2), .INSTR_WIDTH(4), .DEPTH_WIDTH(1)) dut_b (
        .clock(clk), .reset(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_last(b_last), .prg_we(b_we), .prg_addr(b_addr),
        .prg_data(b_pdata), .prg_len(b_len), .cpu_hold(b_hold), .done(b_done),
        .error(b_err)
    );

    // Record every RAM write as addr*16+data, sampled away from the clock edge.
    always @(negedge clk) begin
        if (a_we) log_a.push_back(int'(a_addr) * 16 + int'(a_pdata));
        if (b_we) log_b.push_back(int'(b_addr) * 16 + int'(b_pdata));
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        log_a.delete();
        log_b.delete();
    endtask

    task automatic send_str(input bit sel, input string s, input bit gaps, input bit with_last);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (!sel) begin
                a_valid = 1'b1; a_data = s[i]; a_last = with_last && (i == s.len() - 1);
            end else begin
                b_valid = 1'b1; b_data = s[i]; b_last = with_last && (i == s.len() - 1);
            end
            if (gaps) begin
                @(negedge clk);
                a_valid = 1'b0; b_valid = 1'b0;
                a_data = 8'h2B; b_data = 8'h2B;
            end
        end
        @(negedge clk);
        a_valid = 1'b0; a_last = 1'b0;
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_ready, a_we, a_hold, a_done, a_err} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp %b", {a_ready, a_we, a_hold, a_done, a_err}, 5'b10100);
        end
        checks++;
        if ({a_addr, a_pdata, a_len} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {a_addr, a_pdata, a_len});
        end
    endtask

    task automatic test_basic();
        int exp_q[$] = '{'h00, 'h14, 'h21, 'h32, 'h40, 'h53, 'h65, 'h76, 'h8F};
        do_reset();
        send_str(0, "+[->+<].", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_a.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d exp %0d", log_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (((i < log_a.size()) ? log_a[i] : -1) !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_write%0d got %0h exp %0h", i, (i < log_a.size()) ? log_a[i] : -1, exp_q[i]);
            end
        end
        checks++;
        if ({a_len, a_done, a_hold, a_err, a_ready} !== {8'd8, 4'b1000}) begin
            errors++;
            $display("FAIL basic_status got %h exp %h", {a_len, a_done, a_hold, a_err, a_ready}, {8'd8, 4'b1000});
        end
        // A byte offered after completion must be ignored.
        send_str(0, "+", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_a.size() !== 9 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL after_done got writes=%0d done=%b exp writes=9 done=1", log_a.size(), a_done);
        end
    endtask

    task automatic test_comments();
        int exp_q[$] = '{'h00, 'h11, 'h2F};
        do_reset();
        send_str(0, "a+ b\n-", 1, 1);
        wait_cycles(3);
        checks++;
        if (log_a.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL comment_count got %0d exp %0d", log_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (((i < log_a.size()) ? log_a[i] : -1) !== exp_q[i]) begin
                errors++;
                $display("FAIL comment_write%0d got %0h exp %0h", i, (i < log_a.size()) ? log_a[i] : -1, exp_q[i]);
            end
        end
        checks++;
        if ({a_len, a_done} !== {8'd2, 1'b1}) begin
            errors++;
            $display("FAIL comment_status got %h exp %h", {a_len, a_done}, {8'd2, 1'b1});
        end
    endtask

    task automatic test_stray_close();
        do_reset();
        send_str(0, "]", 0, 1);
        checks++;
        if ({a_err, a_we, a_ready, a_hold, a_done} !== 5'b10010) begin
            errors++;
            $display("FAIL stray_close got %b exp %b", {a_err, a_we, a_ready, a_hold, a_done}, 5'b10010);
        end
        wait_cycles(3);
        checks++;
        if (log_a.size() !== 0 || a_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_close_sticky got writes=%0d err=%b exp 0/1", log_a.size(), a_err);
        end
    endtask

    task automatic test_unclosed();
        int exp_q[$] = '{'h04, 'h14, 'h20, 'h35, 'h4F};
        do_reset();
        send_str(0, "[[+]", 0, 1);
        wait_cycles(3);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (((i < log_a.size()) ? log_a[i] : -1) !== exp_q[i]) begin
                errors++;
                $display("FAIL unclosed_write%0d got %0h exp %0h", i, (i < log_a.size()) ? log_a[i] : -1, exp_q[i]);
            end
        end
        checks++;
        if ({a_err, a_done, a_hold} !== 3'b101) begin
            errors++;
            $display("FAIL unclosed_status got %b exp 101", {a_err, a_done, a_hold});
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_str(0, "xy", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_a.size() !== 1 || ((log_a.size() > 0) ? log_a[0] : -1) !== 'h0F) begin
            errors++;
            $display("FAIL empty_halt got n=%0d first=%0h exp n=1 first=f", log_a.size(), (log_a.size() > 0) ? log_a[0] : -1);
        end
        checks++;
        if ({a_len, a_done} !== {8'd0, 1'b1}) begin
            errors++;
            $display("FAIL empty_status got %h exp %h", {a_len, a_done}, {8'd0, 1'b1});
        end
    endtask

    task automatic test_capacity();
        int full_q[$] = '{'h00, 'h10, 'h20, 'h3F};
        int over_q[$] = '{'h00, 'h10, 'h20};
        do_reset();
        send_str(1, "+++", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_b != full_q) begin
            errors++;
            $display("FAIL cap_full got n=%0d exp n=4 with halt at 3", log_b.size());
        end
        checks++;
        if ({b_len, b_done, b_hold} !== {2'd3, 2'b10}) begin
            errors++;
            $display("FAIL cap_full_status got %b exp %b", {b_len, b_done, b_hold}, {2'd3, 2'b10});
        end
        do_reset();
        send_str(1, "++++", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_b != over_q) begin
            errors++;
            $display("FAIL cap_over got n=%0d exp n=3 nothing at addr 3", log_b.size());
        end
        checks++;
        if ({b_err, b_done, b_ready} !== 3'b100) begin
            errors++;
            $display("FAIL cap_over_status got %b exp 100", {b_err, b_done, b_ready});
        end
    endtask

    task automatic test_depth_limit();
        do_reset();
        send_str(1, "[[", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_b.size() !== 1 || ((log_b.size() > 0) ? log_b[0] : -1) !== 'h04 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL depth_limit got n=%0d err=%b exp n=1 err=1", log_b.size(), b_err);
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_str(0, "+-", 0, 0);
        wait_cycles(1);
        checks++;
        if (log_a.size() !== 2) begin
            errors++;
            $display("FAIL midload_pre got %0d exp 2", log_a.size());
        end
        do_reset();
        checks++;
        if ({a_ready, a_we, a_hold, a_done, a_err, a_addr, a_pdata, a_len} !== {5'b10100, 20'h0}) begin
            errors++;
            $display("FAIL midload_reset got %h exp %h", {a_ready, a_we, a_hold, a_done, a_err, a_addr, a_pdata, a_len}, {5'b10100, 20'h0});
        end
        send_str(0, "-", 0, 1);
        wait_cycles(3);
        checks++;
        if (log_a.size() !== 2 || ((log_a.size() > 1) ? log_a[0] * 256 + log_a[1] : -1) !== 'h011F) begin
            errors++;
            $display("FAIL reload_writes got n=%0d exp 01,1f", log_a.size());
        end
        checks++;
        if ({a_done, a_len} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL reload_status got %h exp %h", {a_done, a_len}, {1'b1, 8'd1});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_comments();
        test_stray_close();
        test_unclosed();
        test_empty();
        test_capacity();
        test_depth_limit();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
